matrix_mult_unit: RTL and testbench
===================================

// Module: matrix_mult_unit
// PURPOSE
// Responder side of the exec-engine module handshake (EN/RW/matDecide/fleg) for matrix multiply.
// Engine writes operand A (matDecide=0) and operand B (matDecide=1) over a 256-bit bus, then issues
// a read (RW=0); the unit computes C = A x B sequentially and returns C with a fleg acknowledge.
// Sits beside memory/register/add/transpose responders on the engine's toModuleBus/fromMultBus.
// PARAMETERS
// DIM     4   matrix dimension (DIM x DIM); only 4 is verified
// ELEM_W  16  element width in bits; bus width = DIM*DIM*ELEM_W (256 at defaults)
// PORTS
// clk        in   1    system clock, all state updates on posedge
// RESET      in   1    synchronous, active-high reset
// enable     in   1    request strobe from engine (multEN); level-held until fleg seen
// RW         in   1    1 = write operand from dataInBus, 0 = compute and return result
// matDecide  in   1    operand select on write: 0 -> A, 1 -> B; ignored when RW=0
// dataInBus  in   256  operand matrix; element (i,j) at [i*64+16*j +:16]
// dataOut    out  256  result matrix C, same packing; registered
// fleg       out  1    acknowledge; rising edge = request complete
// BEHAVIOUR
// - Reset (RESET=1 at posedge): state=IDLE, fleg=0, dataOut=0, A=0, B=0, element index=0.
//   Reset wins over every other condition, including mid-CALC (operation aborted, no fleg).
// - FSM states: IDLE, CALC, ACK.
//   IDLE: enable=1 & RW=1 -> latch dataInBus into A or B per matDecide, fleg<=1, -> ACK.
//         enable=1 & RW=0 -> idx<=0, -> CALC.   enable=0 -> stay, fleg=0.
//   CALC: one output element per cycle, idx 0..15 row-major (idx = i*4+j).
//         C[i][j] = sum_k A[i][k]*B[k][j]; each product truncated to ELEM_W, sum mod 2^ELEM_W
//         (unsigned, wrap-around, no saturation, no overflow flag).
//         Elements accumulate in an internal result register; dataOut unchanged during CALC.
//         idx==15: dataOut <= complete result, fleg<=1, -> ACK.
//   ACK:  fleg held 1 while enable=1; when enable=0 sampled: fleg<=0, -> IDLE.
// - Latency (edges after the edge that samples enable in IDLE): write ack 1 edge;
//   compute: 16 edges (fleg and final dataOut visible together after the 16th).
// - enable, RW, matDecide, dataInBus ignored outside IDLE; changes during CALC have no effect.
// - enable dropped during CALC: computation still completes; fleg rises, then falls next edge
//   (one-cycle pulse) since ACK sees enable=0.
// - enable high on the first edge after reset is a valid new request.
// - Writes never modify dataOut; A/B retain values across computes (operand reuse allowed).
// - Compute with unwritten operands uses reset value 0 -> result 0.
// TESTING
// 1. Assert RESET 2 cycles with enable=1 -> dataOut=0, fleg=0 throughout, state IDLE after release.
// 2. Write A=identity, B elements 1..16 (row-major), compute -> fleg after 16 edges, dataOut == B.
// 3. A all 0x00FF, B all 0x0002 -> every element 0x07F8; A,B all 0x0100 -> every element 0x0000 (wrap).
// 4. Hold enable high 5 cycles past fleg rise -> fleg stays 1; drop enable -> fleg 0 next edge, IDLE.
// 5. RESET at 7th CALC cycle -> fleg never rises, dataOut stays 0, A/B read back 0 on next compute.
// 6. Drop enable at 3rd CALC cycle, toggle RW/matDecide/dataInBus -> correct C, fleg one-cycle pulse.

Source files
------------

// File: rtl/matrix_mult_unit.sv
// Matrix multiply responder for the exec-engine EN/RW/matDecide/fleg handshake.
// Operands are written whole; C = A x B is produced one element per cycle and published at once.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for a request; fleg low
// S_CALC | computing one element of C per cycle, idx 0..DIM*DIM-1
// S_ACK  | request complete; fleg held high until enable drops
module matrix_mult_unit #(
    parameter int DIM    = 4,
    parameter int ELEM_W = 16
) (
    input  logic                      clk,
    input  logic                      RESET,
    input  logic                      enable,
    input  logic                      RW,
    input  logic                      matDecide,
    input  logic [DIM*DIM*ELEM_W-1:0] dataInBus,
    output logic [DIM*DIM*ELEM_W-1:0] dataOut,
    output logic                      fleg
);

    localparam int N_ELEM = DIM * DIM;
    localparam int BUS_W  = N_ELEM * ELEM_W;
    localparam int IDX_W  = $clog2(N_ELEM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_ACK
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               fleg_next;
    logic               load_a;
    logic               load_b;
    logic               start_calc;
    logic               step;
    logic               publish;

    logic [BUS_W-1:0]   mat_a;
    logic [BUS_W-1:0]   mat_b;
    logic [BUS_W-1:0]   result;
    logic [BUS_W-1:0]   result_next;
    logic [IDX_W-1:0]   idx;
    logic [ELEM_W-1:0]  elem_sum;
    int                 row;
    int                 col;

    // Same-width multiply truncates each product; the running sum wraps mod 2^ELEM_W.
    always_comb begin
        row      = int'(idx) / DIM;
        col      = int'(idx) % DIM;
        elem_sum = '0;
        for (int k = 0; k < DIM; k++) begin
            elem_sum = elem_sum + (mat_a[(row*DIM + k)*ELEM_W +: ELEM_W] *
                                   mat_b[(k*DIM + col)*ELEM_W +: ELEM_W]);
        end
        result_next = result;
        result_next[int'(idx)*ELEM_W +: ELEM_W] = elem_sum;
    end

    always_comb begin
        state_next = state;
        fleg_next  = fleg;
        load_a     = 1'b0;
        load_b     = 1'b0;
        start_calc = 1'b0;
        step       = 1'b0;
        publish    = 1'b0;
        case (state)
            S_IDLE: begin
                fleg_next = 1'b0;
                if (enable) begin
                    if (RW) begin
                        load_a     = ~matDecide;
                        load_b     = matDecide;
                        fleg_next  = 1'b1;
                        state_next = S_ACK;
                    end else begin
                        start_calc = 1'b1;
                        state_next = S_CALC;
                    end
                end
            end
            S_CALC: begin
                step = 1'b1;
                if (idx == LAST_IDX) begin
                    publish    = 1'b1;
                    fleg_next  = 1'b1;
                    state_next = S_ACK;
                end
            end
            S_ACK: begin
                if (!enable) begin
                    fleg_next  = 1'b0;
                    state_next = S_IDLE;
                end
            end
            default: begin
                fleg_next  = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state   <= S_IDLE;
            fleg    <= 1'b0;
            dataOut <= '0;
            mat_a   <= '0;
            mat_b   <= '0;
            result  <= '0;
            idx     <= '0;
        end else begin
            state <= state_next;
            fleg  <= fleg_next;
            if (load_a) begin
                mat_a <= dataInBus;
            end
            if (load_b) begin
                mat_b <= dataInBus;
            end
            if (start_calc) begin
                idx <= '0;
            end else if (step) begin
                idx <= idx + IDX_W'(1);
            end
            if (step) begin
                result <= result_next;
            end
            if (publish) begin
                dataOut <= result_next;
            end
        end
    end

endmodule

// File: tb/tb_matrix_mult_unit.sv
// Directed bench for matrix_mult_unit: a table of operand/result vectors plus
// hand-written sequences for reset, ack hold, mid-compute reset and early enable drop.
module tb_matrix_mult_unit;

    localparam int BUS_W = 256;

    logic             clk = 1'b0;
    logic             RESET;
    logic             enable;
    logic             RW;
    logic             matDecide;
    logic [BUS_W-1:0] dataInBus;
    logic [BUS_W-1:0] dataOut;
    logic             fleg;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    matrix_mult_unit #(.DIM(4), .ELEM_W(16)) dut (
        .clk       (clk),
        .RESET     (RESET),
        .enable    (enable),
        .RW        (RW),
        .matDecide (matDecide),
        .dataInBus (dataInBus),
        .dataOut   (dataOut),
        .fleg      (fleg)
    );

    typedef struct {
        logic [BUS_W-1:0] a;
        logic [BUS_W-1:0] b;
        logic [BUS_W-1:0] c;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input logic ok, input string name,
                         input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [BUS_W-1:0] mk_fill(input logic [15:0] v);
        logic [BUS_W-1:0] m;
        for (int e = 0; e < 16; e++) m[e*16 +: 16] = v;
        return m;
    endfunction

    function automatic logic [BUS_W-1:0] mk_seq();
        logic [BUS_W-1:0] m;
        for (int e = 0; e < 16; e++) m[e*16 +: 16] = 16'(e + 1);
        return m;
    endfunction

    function automatic logic [BUS_W-1:0] mk_ident();
        logic [BUS_W-1:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) m[(i*5)*16 +: 16] = 16'd1;
        return m;
    endfunction

    // every row equals (v0 v1 v2 v3)
    function automatic logic [BUS_W-1:0] mk_cols(input logic [15:0] v0, v1, v2, v3);
        logic [BUS_W-1:0] m;
        for (int i = 0; i < 4; i++) begin
            m[(i*4+0)*16 +: 16] = v0;
            m[(i*4+1)*16 +: 16] = v1;
            m[(i*4+2)*16 +: 16] = v2;
            m[(i*4+3)*16 +: 16] = v3;
        end
        return m;
    endfunction

    // row i is filled with v_i
    function automatic logic [BUS_W-1:0] mk_rows(input logic [15:0] v0, v1, v2, v3);
        logic [BUS_W-1:0] m;
        for (int j = 0; j < 4; j++) begin
            m[(0*4+j)*16 +: 16] = v0;
            m[(1*4+j)*16 +: 16] = v1;
            m[(2*4+j)*16 +: 16] = v2;
            m[(3*4+j)*16 +: 16] = v3;
        end
        return m;
    endfunction

    task automatic write_op(input logic sel, input logic [BUS_W-1:0] m, input string name);
        logic [BUS_W-1:0] prev;
        prev = dataOut;
        @(negedge clk);
        enable = 1'b1; RW = 1'b1; matDecide = sel; dataInBus = m;
        @(negedge clk);
        check(fleg === 1'b1, {name, "_ack"}, BUS_W'(fleg), BUS_W'(1));
        enable = 1'b0;
        @(negedge clk);
        check(fleg === 1'b0, {name, "_ack_drop"}, BUS_W'(fleg), BUS_W'(0));
        check(dataOut === prev, {name, "_out_kept"}, dataOut, prev);
    endtask

    // Request is already driven at the current negedge; result due 17 negedges later.
    task automatic await_result(input logic [BUS_W-1:0] exp, input string name, input logic drop_early);
        logic [BUS_W-1:0] prev;
        logic early;
        logic moved;
        prev  = dataOut;
        early = 1'b0;
        moved = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (fleg !== 1'b0) early = 1'b1;
            if (dataOut !== prev) moved = 1'b1;
            if (drop_early && n == 3) begin
                enable    = 1'b0;
                RW        = 1'b1;
                matDecide = ~matDecide;
                dataInBus = {$urandom, $urandom, $urandom, $urandom,
                             $urandom, $urandom, $urandom, $urandom};
            end
        end
        check(!early, {name, "_no_early_fleg"}, BUS_W'(early), BUS_W'(0));
        check(!moved, {name, "_out_stable_calc"}, dataOut, prev);
        @(negedge clk);
        check(fleg === 1'b1, {name, "_fleg"}, BUS_W'(fleg), BUS_W'(1));
        check(dataOut === exp, {name, "_result"}, dataOut, exp);
    endtask

    task automatic compute(input logic [BUS_W-1:0] exp, input string name);
        @(negedge clk);
        enable = 1'b1; RW = 1'b0; dataInBus = '0;
        await_result(exp, name, 1'b0);
        enable = 1'b0;
        @(negedge clk);
        check(fleg === 1'b0, {name, "_fleg_drop"}, BUS_W'(fleg), BUS_W'(0));
    endtask

    initial begin
        logic bad;

        vecs[0] = '{a: mk_ident(),      b: mk_seq(),          c: mk_seq()};
        vecs[1] = '{a: mk_fill(16'h00FF), b: mk_fill(16'h0002), c: mk_fill(16'h07F8)};
        vecs[2] = '{a: mk_fill(16'h0100), b: mk_fill(16'h0100), c: mk_fill(16'h0000)};
        vecs[3] = '{a: mk_fill(16'h0001), b: mk_seq(),          c: mk_cols(16'd28, 16'd32, 16'd36, 16'd40)};
        vecs[4] = '{a: mk_seq(),        b: mk_fill(16'h0001), c: mk_rows(16'd10, 16'd26, 16'd42, 16'd58)};
        vecs[5] = '{a: mk_seq(),        b: mk_ident(),        c: mk_seq()};
        vecs[6] = '{a: mk_fill(16'h5000), b: mk_fill(16'h0001), c: mk_fill(16'h4000)};
        vecs[7] = '{a: mk_fill(16'h0123), b: mk_fill(16'h0100), c: mk_fill(16'h8C00)};

        // Reset held two cycles with a compute request pending; request proceeds right after.
        RESET = 1'b1; enable = 1'b1; RW = 1'b0; matDecide = 1'b0; dataInBus = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check(fleg === 1'b0, "reset_fleg", BUS_W'(fleg), BUS_W'(0));
            check(dataOut === '0, "reset_out", dataOut, '0);
        end
        RESET = 1'b0;
        await_result('0, "post_reset_compute", 1'b0);
        enable = 1'b0;
        @(negedge clk);
        check(fleg === 1'b0, "post_reset_fleg_drop", BUS_W'(fleg), BUS_W'(0));

        for (int i = 0; i < 8; i++) begin
            write_op(1'b0, vecs[i].a, $sformatf("vec%0d_wa", i));
            write_op(1'b1, vecs[i].b, $sformatf("vec%0d_wb", i));
            compute(vecs[i].c, $sformatf("vec%0d", i));
        end

        // Ack hold: reuse operands from the last vector.
        @(negedge clk);
        enable = 1'b1; RW = 1'b0;
        await_result(mk_fill(16'h8C00), "hold", 1'b0);
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (fleg !== 1'b1) bad = 1'b1;
        end
        check(!bad, "hold_fleg_high", BUS_W'(bad), BUS_W'(0));
        enable = 1'b0;
        @(negedge clk);
        check(fleg === 1'b0, "hold_fleg_drop", BUS_W'(fleg), BUS_W'(0));
        write_op(1'b0, mk_seq(), "idle_after_hold");

        // Reset lands on the 7th compute edge.
        write_op(1'b1, mk_seq(), "abort_wb");
        @(negedge clk);
        enable = 1'b1; RW = 1'b0;
        repeat (6) @(negedge clk);
        RESET = 1'b1; enable = 1'b0;
        @(negedge clk);
        RESET = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (fleg !== 1'b0 || dataOut !== '0) bad = 1'b1;
        end
        check(!bad, "abort_quiet", BUS_W'(bad), BUS_W'(0));
        compute('0, "abort_operands_cleared");

        // Enable dropped mid-compute with junk on the other inputs.
        write_op(1'b0, mk_fill(16'h0001), "drop_wa");
        write_op(1'b1, mk_seq(), "drop_wb");
        @(negedge clk);
        enable = 1'b1; RW = 1'b0; matDecide = 1'b0;
        await_result(mk_cols(16'd28, 16'd32, 16'd36, 16'd40), "drop", 1'b1);
        @(negedge clk);
        check(fleg === 1'b0, "drop_fleg_pulse", BUS_W'(fleg), BUS_W'(0));
        compute(mk_cols(16'd28, 16'd32, 16'd36, 16'd40), "drop_reuse");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
